dmem_arbiter: RTL and testbench

//  Two-master arbiter in front of the single-port data memory (byte-addressed, 2-bit WE

---
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port data memory: round robin with a
// bounded lock for port 1, combinational grant/mux, registered read data per port.
module dmem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic [1:0]            m0_we,
    input  logic [DATA_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_stall,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic [1:0]            m1_we,
    input  logic [DATA_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_stall,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            mem_we,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    logic          last_win;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_cnt_nxt;
    logic          grant0;
    logic          grant1;

    // Grant decision; nothing is granted while reset is held so no write can commit.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (m0_req && !m1_req) begin
                grant0 = 1'b1;
            end else if (m1_req && !m0_req) begin
                grant1 = 1'b1;
            end else if (m0_req && m1_req) begin
                if (last_win && m1_lock && (burst_cnt < CW'(MAX_BURST))) begin
                    grant1 = 1'b1;
                end else if (last_win) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end
        end
    end

    assign m0_gnt   = grant0;
    assign m1_gnt   = grant1;
    assign m0_stall = m0_req & ~grant0;
    assign m1_stall = m1_req & ~grant1;

    // Winner's fields go straight to the memory; idle drives zeros.
    always_comb begin
        mem_we = 2'b00;
        mem_a  = '0;
        mem_wd = '0;
        if (grant1) begin
            mem_we = m1_we;
            mem_a  = m1_addr;
            mem_wd = m1_wdata;
        end else if (grant0) begin
            mem_we = m0_we;
            mem_a  = m0_addr;
            mem_wd = m0_wdata;
        end
    end

    // Locked grants only count while port 0 is actually kept waiting.
    always_comb begin
        burst_cnt_nxt = '0;
        if (grant1 && m1_lock) begin
            if (m0_req) begin
                burst_cnt_nxt = (burst_cnt == CW'(MAX_BURST)) ? burst_cnt : burst_cnt + CW'(1);
            end else begin
                burst_cnt_nxt = burst_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win  <= 1'b1;
            burst_cnt <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            burst_cnt <= burst_cnt_nxt;
            m0_rvalid <= grant0;
            m1_rvalid <= grant1;
            if (grant0) begin
                last_win <= 1'b0;
                m0_rdata <= mem_rd;
            end
            if (grant1) begin
                last_win <= 1'b1;
                m1_rdata <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed memory model
// (word index = addr[7:2]) answering the combinational read port.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req, m1_lock;
    logic [1:0]  m0_we, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_stall, m0_rvalid, m1_gnt, m1_stall, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_stall(m1_stall), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Memory model: untouched words read a fixed pattern, writes commit on posedge.
    bit [31:0] bmem [0:63];
    bit [63:0] bvalid;
    logic [5:0] bidx;

    function automatic logic [31:0] init_word(input logic [5:0] i);
        if (i == 6'd0) return 32'hDEADBEEF;
        if (i == 6'd8) return 32'h11223344;
        return 32'hA000_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] we,
                                          input logic [1:0] lane, input logic [31:0] d);
        logic [31:0] w;
        w = old;
        case (we)
            2'b01: w = d;
            2'b10: if (lane[1]) w[31:16] = d[15:0]; else w[15:0] = d[15:0];
            2'b11: w[{lane, 3'b000} +: 8] = d[7:0];
            default: w = old;
        endcase
        return w;
    endfunction

    assign bidx   = mem_a[7:2];
    assign mem_rd = bvalid[bidx] ? bmem[bidx] : init_word(bidx);

    always @(posedge clk) begin
        if (rst_n && mem_we != 2'b00) begin
            bmem[bidx]   <= merge(mem_rd, mem_we, mem_a[1:0], mem_wd);
            bvalid[bidx] <= 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        m0_we = 2'b00; m1_we = 2'b00;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick(); tick();
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 2'b01; m1_we = 2'b01;
        #1;
        checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL rst_m0_gnt: got %b expected 0", m0_gnt); end
        checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL rst_m1_gnt: got %b expected 0", m1_gnt); end
        checks++; if (mem_we !== 2'b00) begin errors++; $display("FAIL rst_mem_we: got %b expected 00", mem_we); end
        tick();
        checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b expected 00", m0_rvalid, m1_rvalid); end
        checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h %h expected 0 0", m0_rdata, m1_rdata); end
        checks++; if (dut.last_win !== 1'b1) begin errors++; $display("FAIL rst_last_win: got %b expected 1", dut.last_win); end
        checks++; if (dut.burst_cnt !== 3'd0) begin errors++; $display("FAIL rst_burst_cnt: got %0d expected 0", dut.burst_cnt); end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        m0_req = 1'b1; m0_addr = 32'h40;
        m1_req = 1'b1; m1_addr = 32'h44;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_a = (k % 2 == 0) ? 32'h40 : 32'h44;
            exp_d = (k % 2 == 0) ? 32'hA000_0010 : 32'hA000_0011;
            checks++; if (m0_gnt !== (k % 2 == 0)) begin errors++; $display("FAIL rr_m0_gnt[%0d]: got %b expected %b", k, m0_gnt, (k % 2 == 0)); end
            checks++; if (m1_gnt !== (k % 2 == 1)) begin errors++; $display("FAIL rr_m1_gnt[%0d]: got %b expected %b", k, m1_gnt, (k % 2 == 1)); end
            checks++; if (m0_stall !== (k % 2 == 1) || m1_stall !== (k % 2 == 0)) begin errors++; $display("FAIL rr_stall[%0d]: got %b%b", k, m0_stall, m1_stall); end
            checks++; if (mem_a !== exp_a) begin errors++; $display("FAIL rr_mem_a[%0d]: got %h expected %h", k, mem_a, exp_a); end
            tick();
            checks++; if (m0_rvalid !== (k % 2 == 0) || m1_rvalid !== (k % 2 == 1)) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b%b", k, m0_rvalid, m1_rvalid); end
            if (k % 2 == 0) begin
                checks++; if (m0_rdata !== exp_d) begin errors++; $display("FAIL rr_m0_rdata[%0d]: got %h expected %h", k, m0_rdata, exp_d); end
            end else begin
                checks++; if (m1_rdata !== exp_d) begin errors++; $display("FAIL rr_m1_rdata[%0d]: got %h expected %h", k, m1_rdata, exp_d); end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_single_read();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m0_req = 1'b1; m0_we = 2'b00; m0_addr = 32'h0001_0000;
        #1;
        checks++; if (m0_gnt !== 1'b1 || m0_stall !== 1'b0) begin errors++; $display("FAIL rd_m0_gnt: got gnt=%b stall=%b expected 1 0", m0_gnt, m0_stall); end
        checks++; if (mem_a !== 32'h0001_0000 || mem_we !== 2'b00) begin errors++; $display("FAIL rd_mem: got a=%h we=%b expected 00010000 00", mem_a, mem_we); end
        tick();
        m0_req = 1'b0;
        checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL rd_m0_rvalid: got %b expected 1", m0_rvalid); end
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_m0_rdata: got %h expected deadbeef", m0_rdata); end
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_m1_rvalid: got %b expected 0", m1_rvalid); end
        tick();
        checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got %b %h expected 0 deadbeef", m0_rvalid, m0_rdata); end
        idle_inputs();
    endtask

    task automatic test_burst();
        logic [5:0] exp_g1;
        int         exp_cnt [6];
        exp_g1  = 6'b011110;
        exp_cnt = '{0, 1, 2, 3, 4, 0};
        m0_addr = 32'h40; m1_addr = 32'h44; m1_lock = 1'b1;
        for (int c = 0; c < 6; c++) begin
            m0_req = 1'b1;
            m1_req = (c >= 1);
            #1;
            checks++; if (m1_gnt !== exp_g1[c] || m0_gnt !== ~exp_g1[c]) begin errors++; $display("FAIL burst_gnt[%0d]: got m0=%b m1=%b expected m1=%b", c, m0_gnt, m1_gnt, exp_g1[c]); end
            checks++; if (m0_stall !== exp_g1[c]) begin errors++; $display("FAIL burst_m0_stall[%0d]: got %b expected %b", c, m0_stall, exp_g1[c]); end
            tick();
            checks++; if (dut.burst_cnt !== 3'(exp_cnt[c])) begin errors++; $display("FAIL burst_cnt[%0d]: got %0d expected %0d", c, dut.burst_cnt, exp_cnt[c]); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_byte_write();
        m1_req = 1'b1; m1_we = 2'b11; m1_addr = 32'h20; m1_wdata = 32'hAB;
        #1;
        checks++; if (mem_we !== 2'b11 || mem_a !== 32'h20 || mem_wd !== 32'hAB) begin errors++; $display("FAIL wr_mem: got we=%b a=%h wd=%h expected 11 20 ab", mem_we, mem_a, mem_wd); end
        checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt: got m0=%b m1=%b expected 0 1", m0_gnt, m1_gnt); end
        tick();
        idle_inputs();
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h11223344) begin errors++; $display("FAIL wr_ack: got %b %h expected 1 11223344", m1_rvalid, m1_rdata); end
        checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hA000_0010) begin errors++; $display("FAIL wr_m0_untouched: got %b %h expected 0 a0000010", m0_rvalid, m0_rdata); end
        m0_req = 1'b1; m0_addr = 32'h20;
        tick();
        m0_req = 1'b0;
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h112233AB) begin errors++; $display("FAIL wr_readback: got %b %h expected 1 112233ab", m0_rvalid, m0_rdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_we !== 2'b00) begin errors++; $display("FAIL idle_gnt[%0d]: got %b%b we=%b expected 00 00", c, m0_gnt, m1_gnt, mem_we); end
            checks++; if (mem_a !== 32'h0 || mem_wd !== 32'h0) begin errors++; $display("FAIL idle_bus[%0d]: got %h %h expected 0 0", c, mem_a, mem_wd); end
            tick();
            checks++; if (dut.last_win !== 1'b0 || dut.burst_cnt !== 3'd0) begin errors++; $display("FAIL idle_state[%0d]: got lw=%b cnt=%0d expected 0 0", c, dut.last_win, dut.burst_cnt); end
        end
    endtask

    task automatic test_reset_mid_burst();
        m0_addr = 32'h40; m1_addr = 32'h44; m1_lock = 1'b1;
        m0_req = 1'b1;
        tick();
        m1_req = 1'b1;
        tick(); tick();
        checks++; if (dut.burst_cnt !== 3'd2) begin errors++; $display("FAIL mid_cnt_pre: got %0d expected 2", dut.burst_cnt); end
        m1_we = 2'b01; m1_wdata = 32'h5555_5555;
        rst_n = 1'b0;
        #1;
        checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_we !== 2'b00) begin errors++; $display("FAIL mid_rst_gnt: got %b%b we=%b expected 00 00", m0_gnt, m1_gnt, mem_we); end
        checks++; if (m1_rvalid !== 1'b0 || dut.burst_cnt !== 3'd0 || dut.last_win !== 1'b1) begin errors++; $display("FAIL mid_rst_state: got rv=%b cnt=%0d lw=%b expected 0 0 1", m1_rvalid, dut.burst_cnt, dut.last_win); end
        tick();
        rst_n = 1'b1; m1_lock = 1'b0; m1_we = 2'b00;
        #1;
        checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || m1_stall !== 1'b1) begin errors++; $display("FAIL mid_after_first: got m0=%b m1=%b st=%b expected 1 0 1", m0_gnt, m1_gnt, m1_stall); end
        tick();
        #1;
        checks++; if (m1_gnt !== 1'b1 || m0_rvalid !== 1'b1) begin errors++; $display("FAIL mid_after_second: got m1=%b rv0=%b expected 1 1", m1_gnt, m0_rvalid); end
        checks++; if (bvalid[17] !== 1'b0) begin errors++; $display("FAIL mid_no_write: got %b expected 0", bvalid[17]); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        m0_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            m0_addr = 32'(i * 4);
            #1;
            checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b expected 1", i, m0_gnt); end
            tick();
            exp_d = 32'hA000_0000 | 32'(i);
            checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== exp_d) begin errors++; $display("FAIL b2b_rdata[%0d]: got %b %h expected 1 %h", i, m0_rvalid, m0_rdata, exp_d); end
        end
        idle_inputs();
        tick();
        checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", m0_rvalid); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_burst();
        test_byte_write();
        test_idle();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
